trace_rx_channel: RTL
=====================

Name: trace_rx_channel

Overview:
- Receive-side endpoint of the tracer data stream: accepts beats on the data_rx valid/ready interface and writes them into L2 memory.
- Mirrors the uDMA RX channel configuration/status contract:
  - start address, size, continuous, enable and clear in;
  - enable, pending, current address and bytes left out.
- Sits between the tracer adapter and the L2 interconnect.
- Includes a small elastic buffer so L2 grant latency does not stall the stream.

Parameters:
- L2_AWIDTH_NOAL, 12, byte-address width of L2 window.
- TRANS_SIZE, 16, width of transfer size/bytes-left counters.
- BUFFER_DEPTH, 4, beat FIFO entries (power of two, >=2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cfg_rx_startaddr_i  in  L2_AWIDTH_NOAL  buffer start byte address
- cfg_rx_size_i  in  TRANS_SIZE  buffer size in bytes
- cfg_rx_continuous_i  in  1  auto-reload on completion
- cfg_rx_en_i  in  1  start pulse (single cycle)
- cfg_rx_clr_i  in  1  abort/flush pulse
- cfg_rx_en_o  out  1  transfer active
- cfg_rx_pending_o  out  1  a second transfer is queued
- cfg_rx_curr_addr_o  out  L2_AWIDTH_NOAL  next write byte address
- cfg_rx_bytes_left_o  out  TRANS_SIZE  remaining bytes
- rx_done_o  out  1  one-cycle pulse when a transfer completes
- data_rx_datasize_i  in  2  0=byte, 1=halfword, 2/3=word
- data_rx_data_i  in  32  beat payload, LSB-justified
- data_rx_valid_i  in  1  beat valid
- data_rx_ready_o  out  1  beat accepted when valid&ready
- l2_req_o  out  1  write request
- l2_addr_o  out  L2_AWIDTH_NOAL  word address, bits[1:0]=0
- l2_wdata_o  out  32  lane-replicated write data
- l2_be_o  out  4  byte enables
- l2_gnt_i  in  1  grant; request retires on req&gnt

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM IDLE, shadow registers 0.
- FSM states: IDLE, RUN.
- IDLE -> RUN on cfg_rx_en_i:
  - load curr_addr=startaddr with low bits masked to the beat size of the first accepted beat;
  - load bytes_left=size;
  - cfg_rx_en_o=1 the next cycle.
  - size==0 is ignored and the FSM stays in IDLE.
- cfg_rx_en_i while in RUN:
  - latch startaddr/size/continuous into shadow registers;
  - pending=1.
  - A further en while pending overwrites the shadow registers.
- data_rx_ready_o = (state==RUN) & ~fifo_full & (accepted-but-unwritten bytes < bytes_left).
  - Must not depend combinationally on data_rx_valid_i.
- Accepted beat (size, data) is pushed into the FIFO. The FIFO head drives the L2 port.
- l2_req_o is asserted the cycle after the push at the earliest. Fall-through latency is 1 cycle.
- Request held stable until granted:
  - be = byte 4'b0001<<a[1:0], half 4'b0011<<{a[1],1'b0}, word 4'b1111;
  - data replicated across lanes.
- On grant:
  - pop the FIFO;
  - curr_addr += beat bytes;
  - bytes_left -= min(beat bytes, bytes_left).
  - A beat larger than bytes_left writes only the remaining low-order bytes (be trimmed).
- Completion when bytes_left reaches 0 on a grant. rx_done_o pulses that same cycle. Then:
  - pending: load the shadow registers, clear pending, stay in RUN;
  - else continuous: reload the last start/size, stay in RUN;
  - else: go to IDLE, cfg_rx_en_o=0.
- cfg_rx_clr_i, highest priority:
  - flush the FIFO; drop l2_req_o the next cycle (an outstanding ungranted request is abandoned);
  - pending=0, bytes_left=0, go to IDLE;
  - no rx_done_o.
- Simultaneous clr and en: clr wins and en is ignored.
- Address wrap: curr_addr wraps modulo 2^L2_AWIDTH_NOAL.
- Asynchronous reset mid-transfer: immediate return to reset values; no L2 request is issued after reset.

Optional Feature:
- Macro TRACE_RX_DROP_CNT_EN.
- Enabled:
  - adds output drop_cnt_o (16 bits, reset 0);
  - increments on every cycle with data_rx_valid_i & ~data_rx_ready_o, saturating at 16'hFFFF;
  - cleared by cfg_rx_clr_i.
  - Tracks beats lost by producers that ignore ready.
- Disabled: port and counter absent; all other behaviour identical.

Test Plan:
- Sequential halfword writes: start=0x100, size=8, continuous=0, four halfword beats 0xAAAA..0xDDDD, gnt always 1.
  - Expect 4 writes: addr 0x100/0x100/0x104/0x104 with be 0011/1100/0011/1100.
  - rx_done_o pulses once; en_o falls; bytes_left=0.
- Backpressure: gnt held 0 for 20 cycles with continuous valid.
  - ready drops after BUFFER_DEPTH beats; no beat lost or reordered.
  - l2 addr/data stable while ungranted.
- Continuous reload: start=0x200, size=4, continuous=1, byte beats.
  - Addresses 0x200..0x203, then 0x200 again; rx_done every 4 grants.
- Pending queue: en with start=0x300 size=2 issued mid-transfer.
  - pending_o=1; after completion curr_addr=0x300, pending_o=0, no IDLE cycle.
- Clear and truncation:
  - clr with 3 beats buffered → next cycle req=0, en_o=0, FIFO empty, no rx_done.
  - size=3 with two halfword beats → second write be 0100, done.
- With TRACE_RX_DROP_CNT_EN: valid held 1 while disabled for 10 cycles → drop_cnt_o=10; clr → 0.

Source files
------------

// File: rtl/trace_rx_channel.sv
// Tracer RX endpoint: accepts data_rx beats into an elastic FIFO and writes them to L2.
// Optional macro TRACE_RX_DROP_CNT_EN adds drop_cnt_o, counting cycles with valid & ~ready.
module trace_rx_channel #(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int BUFFER_DEPTH   = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_i,
    input  logic [TRANS_SIZE-1:0]     cfg_rx_size_i,
    input  logic                      cfg_rx_continuous_i,
    input  logic                      cfg_rx_en_i,
    input  logic                      cfg_rx_clr_i,
    output logic                      cfg_rx_en_o,
    output logic                      cfg_rx_pending_o,
    output logic [L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_o,
    output logic [TRANS_SIZE-1:0]     cfg_rx_bytes_left_o,
    output logic                      rx_done_o,
    input  logic [1:0]                data_rx_datasize_i,
    input  logic [31:0]               data_rx_data_i,
    input  logic                      data_rx_valid_i,
    output logic                      data_rx_ready_o,
    output logic                      l2_req_o,
    output logic [L2_AWIDTH_NOAL-1:0] l2_addr_o,
    output logic [31:0]               l2_wdata_o,
    output logic [3:0]                l2_be_o,
    input  logic                      l2_gnt_i,
`ifdef TRACE_RX_DROP_CNT_EN
    output logic [15:0]               drop_cnt_o,
`endif
    output logic                      dbg_state_o
);
    // Handshakes: a beat moves on data_rx when valid & ready at clk_i; an L2 write
    // retires on req & gnt. ready never looks at valid; req/addr/be/wdata hold until gnt.
    localparam int AW = L2_AWIDTH_NOAL;
    localparam int TW = TRANS_SIZE;
    localparam int PW = $clog2(BUFFER_DEPTH);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
    state_e state_q, state_d;

    logic [31:0]   fifo_data_q [BUFFER_DEPTH];
    logic [1:0]    fifo_size_q [BUFFER_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic [TW-1:0] acc_bytes_q, bytes_left_q, cur_size_q, sh_size_q;
    logic [AW-1:0] curr_addr_q, cur_start_q, sh_start_q, eff_addr;
    logic          cur_cont_q, sh_cont_q, pending_q, first_q;

    logic          fifo_full, fifo_empty, push, grant, last, start_ok;
    logic [1:0]    head_size, lane_off;
    logic [31:0]   head_data;
    logic [2:0]    head_bytes, in_bytes, n_bytes;
    logic [4:0]    be_mask;

    function automatic logic [2:0] beat_bytes(input logic [1:0] sz);
        case (sz)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    assign fifo_full  = (count_q == (PW+1)'(BUFFER_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head_size  = fifo_size_q[rd_ptr_q];
    assign head_data  = fifo_data_q[rd_ptr_q];
    assign head_bytes = beat_bytes(head_size);
    assign in_bytes   = beat_bytes(data_rx_datasize_i);
    assign push       = data_rx_valid_i & data_rx_ready_o & ~cfg_rx_clr_i;
    assign grant      = l2_req_o & l2_gnt_i & ~cfg_rx_clr_i;
    assign last       = grant & (bytes_left_q <= TW'(head_bytes));
    assign start_ok   = cfg_rx_en_i & ~cfg_rx_clr_i & (cfg_rx_size_i != '0);
    assign n_bytes    = (bytes_left_q < TW'(head_bytes)) ? bytes_left_q[2:0] : head_bytes;
    assign be_mask    = (5'd1 << n_bytes) - 5'd1;

    // The first beat of a transfer aligns the start address to its own size.
    always_comb begin
        eff_addr = curr_addr_q;
        lane_off = 2'b00;
        if (first_q) begin
            case (head_size)
                2'd0:    eff_addr = curr_addr_q;
                2'd1:    eff_addr[0] = 1'b0;
                default: eff_addr[1:0] = 2'b00;
            endcase
        end
        case (head_size)
            2'd0:    lane_off = eff_addr[1:0];
            2'd1:    lane_off = {eff_addr[1], 1'b0};
            default: lane_off = 2'b00;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (cfg_rx_clr_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_ok) state_d = RUN;
                RUN:     if (last && !pending_q && !start_ok && !cur_cont_q) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        cfg_rx_en_o     = (state_q == RUN);
        dbg_state_o     = state_q;
        data_rx_ready_o = (state_q == RUN) & ~fifo_full & (acc_bytes_q < bytes_left_q);
        l2_req_o        = (state_q == RUN) & ~fifo_empty;
        rx_done_o       = last;
        l2_addr_o       = '0;
        l2_be_o         = '0;
        l2_wdata_o      = '0;
        if (l2_req_o) begin
            l2_addr_o = {eff_addr[AW-1:2], 2'b00};
            l2_be_o   = be_mask[3:0] << lane_off;
            case (head_size)
                2'd0:    l2_wdata_o = {4{head_data[7:0]}};
                2'd1:    l2_wdata_o = {2{head_data[15:0]}};
                default: l2_wdata_o = head_data;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= data_rx_data_i;
            fifo_size_q[wr_ptr_q] <= data_rx_datasize_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            acc_bytes_q  <= '0;
            bytes_left_q <= '0;
            curr_addr_q  <= '0;
            cur_start_q  <= '0;
            cur_size_q   <= '0;
            cur_cont_q   <= 1'b0;
            sh_start_q   <= '0;
            sh_size_q    <= '0;
            sh_cont_q    <= 1'b0;
            pending_q    <= 1'b0;
            first_q      <= 1'b0;
        end else if (cfg_rx_clr_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            acc_bytes_q  <= '0;
            bytes_left_q <= '0;
            pending_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (grant) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q     <= count_q + (PW+1)'(push) - (PW+1)'(grant);
            acc_bytes_q <= acc_bytes_q + (push ? TW'(in_bytes) : '0)
                                       - (grant ? TW'(head_bytes) : '0);
            if (state_q == IDLE) begin
                if (start_ok) begin
                    cur_start_q  <= cfg_rx_startaddr_i;
                    cur_size_q   <= cfg_rx_size_i;
                    cur_cont_q   <= cfg_rx_continuous_i;
                    curr_addr_q  <= cfg_rx_startaddr_i;
                    bytes_left_q <= cfg_rx_size_i;
                    first_q      <= 1'b1;
                end
            end else begin
                // An en that coincides with a completion and nothing queued starts directly.
                if (start_ok && !(last && !pending_q)) begin
                    sh_start_q <= cfg_rx_startaddr_i;
                    sh_size_q  <= cfg_rx_size_i;
                    sh_cont_q  <= cfg_rx_continuous_i;
                    pending_q  <= 1'b1;
                end
                if (grant) begin
                    curr_addr_q  <= eff_addr + AW'(head_bytes);
                    bytes_left_q <= bytes_left_q - TW'(n_bytes);
                    first_q      <= 1'b0;
                end
                if (last) begin
                    if (pending_q) begin
                        cur_start_q  <= sh_start_q;
                        cur_size_q   <= sh_size_q;
                        cur_cont_q   <= sh_cont_q;
                        curr_addr_q  <= sh_start_q;
                        bytes_left_q <= sh_size_q;
                        first_q      <= 1'b1;
                        if (!start_ok) pending_q <= 1'b0;
                    end else if (start_ok) begin
                        cur_start_q  <= cfg_rx_startaddr_i;
                        cur_size_q   <= cfg_rx_size_i;
                        cur_cont_q   <= cfg_rx_continuous_i;
                        curr_addr_q  <= cfg_rx_startaddr_i;
                        bytes_left_q <= cfg_rx_size_i;
                        first_q      <= 1'b1;
                    end else if (cur_cont_q) begin
                        curr_addr_q  <= cur_start_q;
                        bytes_left_q <= cur_size_q;
                        first_q      <= 1'b1;
                    end
                end
            end
        end
    end

    assign cfg_rx_pending_o    = pending_q;
    assign cfg_rx_curr_addr_o  = curr_addr_q;
    assign cfg_rx_bytes_left_o = bytes_left_q;

`ifdef TRACE_RX_DROP_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                    drop_cnt_o <= '0;
        else if (cfg_rx_clr_i)                          drop_cnt_o <= '0;
        else if (data_rx_valid_i && !data_rx_ready_o && drop_cnt_o != 16'hFFFF)
                                                        drop_cnt_o <= drop_cnt_o + 16'd1;
    end
`endif

endmodule
